// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter: FSM states, owner
// encoding and the access-size field width.
package sram_bus_arbiter_pkg;

   localparam int BUS_ACC_COUNT = 4;
   localparam int ACC_W_DEF     = $clog2(BUS_ACC_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_D = 1'b0,
      OWN_I = 1'b1
   } owner_t;

endpackage

// File: rtl/sram_bus_arbiter_slot.sv
// Single-entry request latch: pending flag plus the captured
// request fields, held until the next accepted request.
module bus_req_slot
   import sram_bus_arbiter_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUS_WIDTH = 32,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 clear,
   input  logic [XLEN-1:0]      req_addr,
   input  logic                 req_w_rb,
   input  logic [ACC_W-1:0]     req_acc,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   output logic                 pending,
   output logic [XLEN-1:0]      addr,
   output logic                 w_rb,
   output logic [ACC_W-1:0]     acc,
   output logic [BUS_WIDTH-1:0] wdata
);

   // A load granted on the same edge never becomes pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         addr    <= '0;
         w_rb    <= 1'b0;
         acc     <= '0;
         wdata   <= '0;
      end else begin
         if (clear)
            pending <= 1'b0;
         else if (load)
            pending <= 1'b1;
         if (load) begin
            addr  <= req_addr;
            w_rb  <= req_w_rb;
            acc   <= req_acc;
            wdata <= req_wdata;
         end
      end
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for the SRAM controller bus: data side has
// priority, bounded by a starvation limit, with a response timeout.
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int BUS_WIDTH    = 32,
   parameter int ACC_W        = ACC_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [XLEN-1:0]      d_addr,
   input  logic                 d_w_rb,
   input  logic [ACC_W-1:0]     d_acc,
   input  logic [BUS_WIDTH-1:0] d_wdata,
   input  logic                 d_req,
   output logic [BUS_WIDTH-1:0] d_rdata,
   output logic                 d_resp,
   output logic                 d_fault,
   input  logic [XLEN-1:0]      i_addr,
   input  logic                 i_w_rb,
   input  logic [ACC_W-1:0]     i_acc,
   input  logic [BUS_WIDTH-1:0] i_wdata,
   input  logic                 i_req,
   output logic [BUS_WIDTH-1:0] i_rdata,
   output logic                 i_resp,
   output logic                 i_fault,
   output logic [XLEN-1:0]      addr,
   output logic                 w_rb,
   output logic [ACC_W-1:0]     acc,
   output logic [BUS_WIDTH-1:0] wdata,
   output logic                 req,
   input  logic [BUS_WIDTH-1:0] rdata,
   input  logic                 resp,
   input  logic                 fault
);

   localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
   localparam int CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t               state, state_next;
   owner_t               owner;
   logic [STREAK_W-1:0]  streak;
   logic [CNT_W-1:0]     cnt;

   logic                 d_pend, i_pend;
   logic                 d_busy, i_busy;
   logic                 d_take, i_take;
   logic                 d_avail, i_avail;
   logic                 pick_i, grant, done;

   logic [XLEN-1:0]      d_s_addr, i_s_addr;
   logic                 d_s_w_rb, i_s_w_rb;
   logic [ACC_W-1:0]     d_s_acc, i_s_acc;
   logic [BUS_WIDTH-1:0] d_s_wdata, i_s_wdata;

   assign d_busy = (state != IDLE) && (owner == OWN_D);
   assign i_busy = (state != IDLE) && (owner == OWN_I);
   assign d_take = d_req && !d_pend && !d_busy;
   assign i_take = i_req && !i_pend && !i_busy;

   // Incoming requests bypass into arbitration for 1-cycle latency.
   assign d_avail = d_pend || d_take;
   assign i_avail = i_pend || i_take;
   assign pick_i  = i_avail && (!d_avail || streak >= LIMIT);
   assign grant   = (state == IDLE) && (d_avail || i_avail);
   assign done    = (state == WAIT) && (resp || cnt == '0);

   bus_req_slot #(
      .XLEN(XLEN), .BUS_WIDTH(BUS_WIDTH), .ACC_W(ACC_W)
   ) u_d_slot (
      .clk(clk), .rst(rst),
      .load(d_take), .clear(grant && !pick_i),
      .req_addr(d_addr), .req_w_rb(d_w_rb),
      .req_acc(d_acc), .req_wdata(d_wdata),
      .pending(d_pend), .addr(d_s_addr), .w_rb(d_s_w_rb),
      .acc(d_s_acc), .wdata(d_s_wdata)
   );

   bus_req_slot #(
      .XLEN(XLEN), .BUS_WIDTH(BUS_WIDTH), .ACC_W(ACC_W)
   ) u_i_slot (
      .clk(clk), .rst(rst),
      .load(i_take), .clear(grant && pick_i),
      .req_addr(i_addr), .req_w_rb(i_w_rb),
      .req_acc(i_acc), .req_wdata(i_wdata),
      .pending(i_pend), .addr(i_s_addr), .w_rb(i_s_w_rb),
      .acc(i_s_acc), .wdata(i_s_wdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= OWN_D;
         streak <= '0;
         cnt    <= '0;
      end else begin
         state <= state_next;
         if (grant) begin
            owner <= pick_i ? OWN_I : OWN_D;
            if (pick_i || !i_avail)
               streak <= '0;
            else if (streak != LIMIT)
               streak <= streak + 1'b1;
         end
         if (state == ISSUE)
            cnt <= CNT_LOAD;
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (grant) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Slot fields stay frozen while owned, so the bus holds stable.
   assign addr  = (owner == OWN_I) ? i_s_addr  : d_s_addr;
   assign w_rb  = (owner == OWN_I) ? i_s_w_rb  : d_s_w_rb;
   assign acc   = (owner == OWN_I) ? i_s_acc   : d_s_acc;
   assign wdata = (owner == OWN_I) ? i_s_wdata : d_s_wdata;
   assign req   = (state == ISSUE);

   assign d_resp  = done && (owner == OWN_D);
   assign i_resp  = done && (owner == OWN_I);
   assign d_fault = d_resp && (resp ? fault : 1'b1);
   assign i_fault = i_resp && (resp ? fault : 1'b1);
   assign d_rdata = (d_resp && resp) ? rdata : '0;
   assign i_rdata = (i_resp && resp) ? rdata : '0;

   a_d_proto: assert property (@(posedge clk) disable iff (rst)
      !(d_req && (d_pend || d_busy)));
   a_i_proto: assert property (@(posedge clk) disable iff (rst)
      !(i_req && (i_pend || i_busy)));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter
// (STARVE_LIMIT=4, TIMEOUT=8).
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d_addr, i_addr, addr;
   logic        d_w_rb, i_w_rb, w_rb;
   logic [1:0]  d_acc, i_acc, acc;
   logic [31:0] d_wdata, i_wdata, wdata;
   logic        d_req, i_req, req;
   logic [31:0] d_rdata, i_rdata, rdata;
   logic        d_resp, i_resp, resp;
   logic        d_fault, i_fault, fault;

   int vecs = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter #(
      .XLEN(32), .BUS_WIDTH(32), .ACC_W(2),
      .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc),
      .d_wdata(d_wdata), .d_req(d_req), .d_rdata(d_rdata),
      .d_resp(d_resp), .d_fault(d_fault),
      .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc),
      .i_wdata(i_wdata), .i_req(i_req), .i_rdata(i_rdata),
      .i_resp(i_resp), .i_fault(i_fault),
      .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
      .req(req), .rdata(rdata), .resp(resp), .fault(fault)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      d_req = 0; i_req = 0; resp = 0; fault = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      d_addr = 0; d_w_rb = 0; d_acc = 0; d_wdata = 0;
      i_addr = 0; i_w_rb = 0; i_acc = 0; i_wdata = 0;
      rdata = 0;
      quiet();
      cyc(); cyc();
      #2;
      vecs++;
      if ({req, d_resp, i_resp, d_fault, i_fault} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b want 00000",
                  {req, d_resp, i_resp, d_fault, i_fault});
      end
      vecs++;
      if ({addr, wdata, d_rdata, i_rdata, w_rb, acc} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: addr %h wdata %h want 0",
                  addr, wdata);
      end
      cyc();
      rst = 0;
      cyc();
   endtask

   task automatic test_single_read;
      d_addr = 32'h100; d_w_rb = 0; d_acc = 2'd2; d_req = 1;
      #2;
      vecs++;
      if (req !== 1'b0) begin
         miscompares++;
         $display("FAIL single_c0_req: got %b want 0", req);
      end
      cyc(); d_req = 0; #2;
      vecs++;
      if ({req, addr, w_rb, acc} !== {1'b1, 32'h100, 1'b0, 2'd2}) begin
         miscompares++;
         $display("FAIL single_issue: req %b addr %h w_rb %b acc %0d want 1 100 0 2",
                  req, addr, w_rb, acc);
      end
      cyc(); #2;
      vecs++;
      if ({req, d_resp} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_wait: req %b d_resp %b want 0 0", req, d_resp);
      end
      cyc(); resp = 1; rdata = 32'hDEADBEEF; #2;
      vecs++;
      if ({d_resp, d_rdata, d_fault, i_resp} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
         miscompares++;
         $display("FAIL single_resp: d_resp %b d_rdata %h d_fault %b i_resp %b want 1 deadbeef 0 0",
                  d_resp, d_rdata, d_fault, i_resp);
      end
      cyc(); resp = 0; #2;
      vecs++;
      if ({d_resp, d_rdata} !== 33'b0) begin
         miscompares++;
         $display("FAIL single_after: d_resp %b d_rdata %h want 0 0", d_resp, d_rdata);
      end
      cyc();
   endtask

   task automatic test_simultaneous;
      d_addr = 32'h200; i_addr = 32'h300; d_req = 1; i_req = 1;
      cyc(); quiet(); #2;
      vecs++;
      if ({req, addr} !== {1'b1, 32'h200}) begin
         miscompares++;
         $display("FAIL simul_d_issue: req %b addr %h want 1 200", req, addr);
      end
      cyc(); resp = 1; rdata = 32'h11; #2;
      vecs++;
      if ({d_resp, d_rdata, i_resp} !== {1'b1, 32'h11, 1'b0}) begin
         miscompares++;
         $display("FAIL simul_d_resp: d_resp %b d_rdata %h i_resp %b want 1 11 0",
                  d_resp, d_rdata, i_resp);
      end
      cyc(); resp = 0; #2;
      vecs++;
      if (req !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_idle: req %b want 0", req);
      end
      cyc(); #2;
      vecs++;
      if ({req, addr} !== {1'b1, 32'h300}) begin
         miscompares++;
         $display("FAIL simul_i_issue: req %b addr %h want 1 300", req, addr);
      end
      cyc(); resp = 1; rdata = 32'h22; #2;
      vecs++;
      if ({i_resp, i_rdata, d_resp, d_rdata} !== {1'b1, 32'h22, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL simul_i_resp: i_resp %b i_rdata %h d_resp %b want 1 22 0",
                  i_resp, i_rdata, d_resp);
      end
      cyc(); resp = 0;
      cyc();
   endtask

   task automatic test_starvation;
      logic [31:0] log_q[$];
      logic [31:0] exp_a [6];
      int d_sent;
      bit d_again, resp_nx;
      exp_a = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                32'h2000, 32'h1004};
      d_again = 0; resp_nx = 0;
      d_addr = 32'h1000; i_addr = 32'h2000;
      d_req = 1; i_req = 1; d_sent = 1;
      for (int c = 0; c < 40; c++) begin
         #2;
         if (req) begin
            log_q.push_back(addr);
            resp_nx = 1;
         end
         if (d_resp && d_sent < 5) d_again = 1;
         cyc();
         i_req = 0;
         d_req = d_again;
         if (d_again) begin
            d_addr = 32'h1000 + d_sent;
            d_sent++;
         end
         d_again = 0;
         resp = resp_nx; rdata = 32'h0; resp_nx = 0;
      end
      quiet();
      vecs++;
      if (log_q.size() != 6) begin
         miscompares++;
         $display("FAIL starve_count: got %0d grants want 6", log_q.size());
      end
      for (int k = 0; k < 6 && k < log_q.size(); k++) begin
         vecs++;
         if (log_q[k] !== exp_a[k]) begin
            miscompares++;
            $display("FAIL starve_order[%0d]: addr %h want %h",
                     k, log_q[k], exp_a[k]);
         end
      end
      cyc();
   endtask

   task automatic test_timeout;
      bit early;
      early = 0;
      i_addr = 32'h400; i_w_rb = 0; i_req = 1;
      rdata = 32'hFFFF_FFFF;
      cyc(); i_req = 0; #2;
      vecs++;
      if ({req, addr} !== {1'b1, 32'h400}) begin
         miscompares++;
         $display("FAIL tmo_issue: req %b addr %h want 1 400", req, addr);
      end
      for (int c = 2; c <= 8; c++) begin
         cyc(); #2;
         if (i_resp || d_resp) early = 1;
      end
      vecs++;
      if (early) begin
         miscompares++;
         $display("FAIL tmo_early: got early resp want none before cycle 8");
      end
      cyc(); #2;
      vecs++;
      if ({i_resp, i_fault, i_rdata, d_resp} !== {2'b11, 32'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL tmo_fire: i_resp %b i_fault %b i_rdata %h d_resp %b want 1 1 0 0",
                  i_resp, i_fault, i_rdata, d_resp);
      end
      cyc(); cyc(); resp = 1; rdata = 32'h55; #2;
      vecs++;
      if ({i_resp, d_resp, i_rdata} !== 34'b0) begin
         miscompares++;
         $display("FAIL tmo_late_resp: i_resp %b d_resp %b i_rdata %h want 0 0 0",
                  i_resp, d_resp, i_rdata);
      end
      cyc(); resp = 0;
      cyc();
   endtask

   task automatic test_fault;
      d_addr = 32'h500; d_w_rb = 1; d_wdata = 32'h12345678; d_req = 1;
      cyc();
      d_req = 0; d_addr = 0; d_wdata = 0; d_w_rb = 0;
      #2;
      vecs++;
      if ({req, w_rb, wdata, addr} !== {2'b11, 32'h12345678, 32'h500}) begin
         miscompares++;
         $display("FAIL fault_issue: req %b w_rb %b wdata %h addr %h want 1 1 12345678 500",
                  req, w_rb, wdata, addr);
      end
      cyc(); #2;
      vecs++;
      if ({w_rb, wdata, addr} !== {1'b1, 32'h12345678, 32'h500}) begin
         miscompares++;
         $display("FAIL fault_hold: w_rb %b wdata %h addr %h want 1 12345678 500",
                  w_rb, wdata, addr);
      end
      cyc(); resp = 1; fault = 1; rdata = 32'h0; #2;
      vecs++;
      if ({d_resp, d_fault, i_resp, wdata, addr} !==
          {3'b110, 32'h12345678, 32'h500}) begin
         miscompares++;
         $display("FAIL fault_resp: d_resp %b d_fault %b i_resp %b wdata %h addr %h want 1 1 0 12345678 500",
                  d_resp, d_fault, i_resp, wdata, addr);
      end
      cyc(); quiet();
      cyc();
   endtask

   task automatic test_reset_mid;
      bit stray;
      stray = 0;
      d_addr = 32'h700; d_wdata = 32'hCAFE; d_w_rb = 1;
      i_addr = 32'h800;
      d_req = 1; i_req = 1;
      cyc(); quiet();
      cyc();
      rst = 1; #2;
      vecs++;
      if ({req, d_resp, i_resp, d_fault, i_fault, addr, wdata, w_rb} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_now: req %b d_resp %b i_resp %b addr %h wdata %h want all 0",
                  req, d_resp, i_resp, addr, wdata);
      end
      cyc(); rst = 0; d_w_rb = 0;
      for (int c = 0; c < 6; c++) begin
         #2;
         if (req || d_resp || i_resp) stray = 1;
         cyc();
      end
      vecs++;
      if (stray) begin
         miscompares++;
         $display("FAIL rstmid_stray: got activity after reset want none");
      end
      d_addr = 32'h600; d_req = 1;
      cyc(); d_req = 0; #2;
      vecs++;
      if ({req, addr} !== {1'b1, 32'h600}) begin
         miscompares++;
         $display("FAIL rstmid_fresh_issue: req %b addr %h want 1 600", req, addr);
      end
      cyc(); resp = 1; rdata = 32'h77; #2;
      vecs++;
      if ({d_resp, d_rdata, i_resp} !== {1'b1, 32'h77, 1'b0}) begin
         miscompares++;
         $display("FAIL rstmid_fresh_resp: d_resp %b d_rdata %h i_resp %b want 1 77 0",
                  d_resp, d_rdata, i_resp);
      end
      cyc(); quiet();
      cyc();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_starvation();
      test_timeout();
      test_fault();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
